csr_m_unit: RTL

Machine-mode CSR unit; successor to the single-purpose trap CSR block. Adds `mstatus` interrupt-enable stacking, `mie`/`mip` with three synchronised interrupt lines, vectored `mtvec`, `mtval`, 64-bit `mcycle`/`minstret`, and illegal-CSR detection. Sits beside the execute stage; the core presents one instruction per `valid_i` and redirects fetch on `raise_trap_o`.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/csr_counter64.sv | 41 ++++
 rtl/csr_m_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared machine-mode CSR definitions: operation codes, CSR addresses,
// mcause codes and bit positions inside mstatus/mie.
package core_pkg;

    typedef enum logic [2:0] {
        OpNone   = 3'd0,
        OpCSRRW  = 3'd1,
        OpCSRRS  = 3'd2,
        OpCSRRC  = 3'd3,
        OpEcall  = 3'd4,
        OpEbreak = 3'd5,
        OpMret   = 3'd6
    } csr_op_e;

    typedef enum logic [11:0] {
        CsrMstatus   = 12'h300,
        CsrMisa      = 12'h301,
        CsrMie       = 12'h304,
        CsrMtvec     = 12'h305,
        CsrMstatush  = 12'h310,
        CsrMscratch  = 12'h340,
        CsrMepc      = 12'h341,
        CsrMcause    = 12'h342,
        CsrMtval     = 12'h343,
        CsrMip       = 12'h344,
        CsrMcycle    = 12'hB00,
        CsrMinstret  = 12'hB02,
        CsrMcycleh   = 12'hB80,
        CsrMinstreth = 12'hB82,
        CsrMhartid   = 12'hF14
    } csr_addr_e;

    typedef enum logic [3:0] {
        IrqMSoft  = 4'd3,
        IrqMTimer = 4'd7,
        IrqMExt   = 4'd11
    } mcause_irq_e;

    typedef enum logic [3:0] {
        ExcIllegal    = 4'd2,
        ExcBreakpoint = 4'd3,
        ExcEcallM     = 4'd11
    } mcause_exc_e;

    localparam int MstatusMie  = 3;
    localparam int MstatusMpie = 7;
    localparam int MieMsie     = 3;
    localparam int MieMtie     = 7;
    localparam int MieMeie     = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half and full-width overwrite.
// A write in a cycle replaces the written part and drops that cycle's increment.
module csr_counter64 #(
    parameter int unsigned Xlen = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic            wr_full_i,
    input  logic [Xlen-1:0] wdata_i,
    output logic [63:0]     count_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_full_i) begin
            cnt_d = 64'(wdata_i);
        end else if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i[31:0];
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wdata_i[31:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/csr_m_unit.sv
// Machine-mode CSR file with trap entry/exit, interrupt arbitration and counters.
// Outputs are combinational from inputs and state; all state moves on the next edge.
module csr_m_unit
    import core_pkg::*;
#(
    parameter int unsigned Xlen       = 32,
    parameter int unsigned MHartId    = 0,
    parameter bit          VectoredEn = 1'b1,
    parameter bit          CounterEn  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  csr_op_e         csr_op_i,
    input  logic            rs1_zero_i,
    input  logic [Xlen-1:0] rs1_data_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [Xlen-1:0] pc_i,
    input  logic            retire_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [Xlen-1:0] rd_data_o,
    output logic            raise_trap_o,
    output logic [Xlen-1:0] trap_vector_o,
    output logic            illegal_o
);

    localparam logic [Xlen-1:0] MisaVal =
        {((Xlen == 32) ? 2'b01 : 2'b10), {(Xlen-11){1'b0}}, 9'h100};
    localparam logic [Xlen-1:0] EpcMask = (Xlen == 32) ? ~Xlen'(3) : ~Xlen'(1);

    // mie/mip bit order below is {MEI, MTI, MSI}
    logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [2:0]      mie_q, mie_d, mip_q, mip_d;
    logic [Xlen-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [Xlen-1:0] mcause_q, mcause_d, mtval_q, mtval_d;

    logic            csr_access, wr_req, addr_ok, illegal, irq_take, trap, do_mret, csr_wr;
    logic            is_ecall, is_ebreak;
    logic [2:0]      irq_vec;
    mcause_irq_e     irq_code;
    logic [Xlen-1:0] old_val, wdata, base;
    logic [63:0]     cyc_cnt, ret_cnt, cyc_val, ret_val;
    logic            cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;

    assign cyc_val = CounterEn ? cyc_cnt : 64'd0;
    assign ret_val = CounterEn ? ret_cnt : 64'd0;

    always_comb begin
        csr_access = valid_i && (csr_op_i inside {OpCSRRW, OpCSRRS, OpCSRRC});
        wr_req     = csr_access && ((csr_op_i == OpCSRRW) || !rs1_zero_i);
        addr_ok    = 1'b1;
        old_val    = '0;
        case (csr_addr_i)
            CsrMhartid:   old_val = Xlen'(MHartId);
            CsrMstatus: begin
                old_val[MstatusMie]  = mst_mie_q;
                old_val[MstatusMpie] = mst_mpie_q;
                old_val[12:11]       = 2'b11;
            end
            CsrMisa:      old_val = MisaVal;
            CsrMie: begin
                old_val[MieMsie] = mie_q[0];
                old_val[MieMtie] = mie_q[1];
                old_val[MieMeie] = mie_q[2];
            end
            CsrMtvec:     old_val = mtvec_q;
            CsrMstatush:  addr_ok = (Xlen == 32);
            CsrMscratch:  old_val = mscratch_q;
            CsrMepc:      old_val = mepc_q;
            CsrMcause:    old_val = mcause_q;
            CsrMtval:     old_val = mtval_q;
            CsrMip: begin
                old_val[MieMsie] = mip_q[0];
                old_val[MieMtie] = mip_q[1];
                old_val[MieMeie] = mip_q[2];
            end
            CsrMcycle:    old_val = cyc_val[Xlen-1:0];
            CsrMinstret:  old_val = ret_val[Xlen-1:0];
            CsrMcycleh: begin
                addr_ok = (Xlen == 32);
                old_val = Xlen'(cyc_val[63:32]);
            end
            CsrMinstreth: begin
                addr_ok = (Xlen == 32);
                old_val = Xlen'(ret_val[63:32]);
            end
            default:      addr_ok = 1'b0;
        endcase

        illegal   = csr_access && (!addr_ok || (wr_req && (csr_addr_i[11:10] == 2'b11)));
        irq_vec   = mie_q & mip_q;
        irq_take  = valid_i && mst_mie_q && (|irq_vec);
        irq_code  = irq_vec[2] ? IrqMExt : (irq_vec[0] ? IrqMSoft : IrqMTimer);
        is_ecall  = valid_i && (csr_op_i == OpEcall);
        is_ebreak = valid_i && (csr_op_i == OpEbreak);
        trap      = irq_take || illegal || is_ecall || is_ebreak;
        do_mret   = valid_i && (csr_op_i == OpMret) && !irq_take;
        csr_wr    = wr_req && !illegal && !irq_take;

        case (csr_op_i)
            OpCSRRS: wdata = old_val | rs1_data_i;
            OpCSRRC: wdata = old_val & ~rs1_data_i;
            default: wdata = rs1_data_i;
        endcase
        base = {mtvec_q[Xlen-1:2], 2'b00};

        rd_data_o     = csr_access ? old_val : '0;
        illegal_o     = illegal;
        raise_trap_o  = trap || do_mret;
        trap_vector_o = '0;
        if (do_mret) begin
            trap_vector_o = mepc_q;
        end else if (trap) begin
            trap_vector_o = (irq_take && mtvec_q[0]) ? base + Xlen'({irq_code, 2'b00}) : base;
        end
    end

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mip_d      = {irq_ext_i, irq_timer_i, irq_sw_i};
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap) begin
            mepc_d     = pc_i & EpcMask;
            mcause_d   = irq_take ? {1'b1, {(Xlen-5){1'b0}}, irq_code}
                       : Xlen'(illegal ? ExcIllegal : (is_ecall ? ExcEcallM : ExcBreakpoint));
            mtval_d    = (!irq_take && is_ebreak) ? pc_i : '0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (csr_addr_i)
                CsrMstatus: begin
                    mst_mie_d  = wdata[MstatusMie];
                    mst_mpie_d = wdata[MstatusMpie];
                end
                CsrMie:      mie_d      = {wdata[MieMeie], wdata[MieMtie], wdata[MieMsie]};
                CsrMtvec:    mtvec_d    = {wdata[Xlen-1:2], 1'b0, VectoredEn & wdata[0]};
                CsrMscratch: mscratch_d = wdata;
                CsrMepc:     mepc_d     = wdata & EpcMask;
                CsrMcause:   mcause_d   = wdata;
                CsrMtval:    mtval_d    = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    // Low-half address doubles as the full-width write when Xlen is 64
    assign cyc_wr_lo = CounterEn && csr_wr && (csr_addr_i == CsrMcycle);
    assign cyc_wr_hi = CounterEn && (Xlen == 32) && csr_wr && (csr_addr_i == CsrMcycleh);
    assign ret_wr_lo = CounterEn && csr_wr && (csr_addr_i == CsrMinstret);
    assign ret_wr_hi = CounterEn && (Xlen == 32) && csr_wr && (csr_addr_i == CsrMinstreth);

    csr_counter64 #(.Xlen(Xlen)) u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (CounterEn && !cyc_wr_lo && !cyc_wr_hi),
        .wr_lo_i   ((Xlen == 32) && cyc_wr_lo),
        .wr_hi_i   (cyc_wr_hi),
        .wr_full_i ((Xlen == 64) && cyc_wr_lo),
        .wdata_i   (wdata),
        .count_o   (cyc_cnt)
    );

    csr_counter64 #(.Xlen(Xlen)) u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (CounterEn && retire_i && !ret_wr_lo && !ret_wr_hi),
        .wr_lo_i   ((Xlen == 32) && ret_wr_lo),
        .wr_hi_i   (ret_wr_hi),
        .wr_full_i ((Xlen == 64) && ret_wr_lo),
        .wdata_i   (wdata),
        .count_o   (ret_cnt)
    );

endmodule
